// File: rtl/vdp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdp_pkg
// Description : Shared encodings for the VDP CPU port: display modes,
//               register indices, status bit positions, port selects, FSM.
// Revision    : 1.0  initial release
// ============================================================================
package vdp_pkg;

  // Width of every VRAM table address the display consumes
  localparam int VRAM_AW = 14;

  // Display mode encodings
  localparam logic [1:0] MODE_TEXT       = 2'd0;
  localparam logic [1:0] MODE_GRAPHICS1  = 2'd1;
  localparam logic [1:0] MODE_GRAPHICS2  = 2'd2;
  localparam logic [1:0] MODE_MULTICOLOR = 2'd3;

  // Register indices
  localparam int REG_R0 = 0;
  localparam int REG_R1 = 1;
  localparam int REG_R2 = 2;
  localparam int REG_R3 = 3;
  localparam int REG_R4 = 4;
  localparam int REG_R5 = 5;
  localparam int REG_R6 = 6;
  localparam int REG_R7 = 7;

  // Status byte bit positions (bits 4:0 hold the fifth-sprite number)
  localparam int STAT_F_BIT  = 7;
  localparam int STAT_5S_BIT = 6;
  localparam int STAT_C_BIT  = 5;

  // Port select values
  localparam logic PORT_DATA = 1'b0;
  localparam logic PORT_CTRL = 1'b1;

  // Register file: eight 8-bit VDP registers
  typedef logic [7:0][7:0] vdp_regs_t;

  // CPU-side VRAM access sequencer
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_ISSUE = 2'd1,
    ST_RD_WAIT  = 2'd2
  } vdp_state_t;

endpackage : vdp_pkg
`default_nettype wire

// File: rtl/vdp_reg_decode.sv
`default_nettype none
// ============================================================================
// Module      : vdp_reg_decode
// Description : Purely combinational decode of VDP registers R0-R7 into the
//               display mode, VRAM table base addresses and control flags.
// Revision    : 1.0  initial release
// ============================================================================
module vdp_reg_decode
  import vdp_pkg::*;
(
  input  logic [7:0][7:0]     regs,
  output logic [1:0]          mode,
  output logic [VRAM_AW-1:0]  name_table_addr,
  output logic [VRAM_AW-1:0]  font_addr,
  output logic [VRAM_AW-1:0]  color_table_addr,
  output logic [VRAM_AW-1:0]  sprite_attr_addr,
  output logic [VRAM_AW-1:0]  sprite_pattern_table_addr,
  output logic                video_on,
  output logic                sprite_large,
  output logic                sprite_enlarged,
  output logic                vert_retrace_int,
  output logic [3:0]          text_color,
  output logic [3:0]          back_color
);

  logic w_m1;
  logic w_m2;
  logic w_m3;

  // Register bits the display does not use; gathered so lint sees them consumed
  logic w_unused_bits;
  assign w_unused_bits = ^{regs[REG_R0][7:2], regs[REG_R0][0], regs[REG_R1][7],
                           regs[REG_R1][2], regs[REG_R2][7:4], regs[REG_R4][7:3],
                           regs[REG_R5][7], regs[REG_R6][7:3]};

  assign w_m1 = regs[REG_R1][4];
  assign w_m2 = regs[REG_R1][3];
  assign w_m3 = regs[REG_R0][1];

  // Mode select and table base decode; graphics 2 uses the coarse 8 KB bases
  always_comb begin
    mode                      = MODE_GRAPHICS1;
    name_table_addr           = {regs[REG_R2][3:0], 10'b0};
    sprite_attr_addr          = {regs[REG_R5][6:0], 7'b0};
    sprite_pattern_table_addr = {regs[REG_R6][2:0], 11'b0};
    color_table_addr          = {regs[REG_R3], 6'b0};
    font_addr                 = {regs[REG_R4][2:0], 11'b0};
    video_on                  = regs[REG_R1][6];
    sprite_large              = regs[REG_R1][1];
    sprite_enlarged           = regs[REG_R1][0];
    vert_retrace_int          = regs[REG_R1][5];
    text_color                = regs[REG_R7][7:4];
    back_color                = regs[REG_R7][3:0];

    if (w_m1) begin
      mode = MODE_TEXT;
    end else if (w_m3) begin
      mode = MODE_GRAPHICS2;
    end else if (w_m2) begin
      mode = MODE_MULTICOLOR;
    end else begin
      mode = MODE_GRAPHICS1;
    end

    if (mode == MODE_GRAPHICS2) begin
      color_table_addr = {regs[REG_R3][7], 13'b0};
      font_addr        = {regs[REG_R4][2], 13'b0};
    end
  end

endmodule : vdp_reg_decode
`default_nettype wire

// File: rtl/vdp_cpu_port.sv
`default_nettype none
// ============================================================================
// Module      : vdp_cpu_port
// Description : CPU side of the VDP. Decodes data/control port accesses,
//               sequences VRAM reads/writes, holds R0-R7, latches status and
//               drives the active-low interrupt.
// Revision    : 1.0  initial release
// ============================================================================
module vdp_cpu_port
  import vdp_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int RD_LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                io_wr,
  input  logic                io_rd,
  input  logic                port_sel,
  input  logic [7:0]          cpu_wdata,
  output logic [7:0]          cpu_rdata,
  output logic [ADDR_W-1:0]   vram_addr,
  output logic [7:0]          vram_wdata,
  output logic                vram_wr,
  output logic                vram_rd,
  input  logic [7:0]          vram_rdata,
  input  logic                frame_int,
  input  logic                spr_coll,
  input  logic                spr_5th,
  input  logic [4:0]          spr_5th_num,
  output logic [1:0]          mode,
  output logic [VRAM_AW-1:0]  name_table_addr,
  output logic [VRAM_AW-1:0]  font_addr,
  output logic [VRAM_AW-1:0]  color_table_addr,
  output logic [VRAM_AW-1:0]  sprite_attr_addr,
  output logic [VRAM_AW-1:0]  sprite_pattern_table_addr,
  output logic                video_on,
  output logic                sprite_large,
  output logic                sprite_enlarged,
  output logic                vert_retrace_int,
  output logic [3:0]          text_color,
  output logic [3:0]          back_color,
  output logic                n_int,
  output logic                overrun
);

  localparam int              CNT_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(RD_LATENCY - 1);

  vdp_state_t        r_state;
  vdp_state_t        w_state_nxt;
  logic [CNT_W-1:0]  r_lat_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_vram_addr;
  logic [7:0]        r_vram_wdata;
  logic              r_vram_wr;
  logic [7:0]        r_read_buf;
  logic [7:0]        r_first_byte;
  logic              r_flag;
  logic [7:0]        r_cpu_rdata;
  vdp_regs_t         r_regs;
  logic              r_frame_d;
  logic              r_stat_f;
  logic              r_stat_5s;
  logic              r_stat_c;
  logic [4:0]        r_stat_num;
  logic              r_overrun;

  logic              w_idle;
  logic              w_wr;
  logic              w_rd;
  logic              w_data_wr;
  logic              w_ctl_wr;
  logic              w_data_rd;
  logic              w_stat_rd;
  logic              w_reg_wr;
  logic              w_addr_wr;
  logic              w_start_rd;
  logic              w_rd_done;
  logic              w_busy_strobe;
  logic              w_frame_rise;
  logic              w_vram_rd;
  logic [ADDR_W-1:0] w_new_addr;
  logic [7:0]        w_status;

  // Strobes are only honoured while the sequencer is idle; a write wins a tie
  assign w_idle        = (r_state == ST_IDLE);
  assign w_wr          = io_wr & w_idle;
  assign w_rd          = io_rd & ~io_wr & w_idle;
  assign w_data_wr     = w_wr & (port_sel == PORT_DATA);
  assign w_ctl_wr      = w_wr & (port_sel == PORT_CTRL);
  assign w_data_rd     = w_rd & (port_sel == PORT_DATA);
  assign w_stat_rd     = w_rd & (port_sel == PORT_CTRL);
  assign w_reg_wr      = w_ctl_wr & r_flag & cpu_wdata[7];
  assign w_addr_wr     = w_ctl_wr & r_flag & ~cpu_wdata[7];
  assign w_start_rd    = w_data_rd | (w_addr_wr & ~cpu_wdata[6]);
  assign w_rd_done     = (r_state == ST_RD_WAIT) && (r_lat_cnt == LAT_LAST);
  assign w_busy_strobe = (io_wr | io_rd) & ~w_idle;
  assign w_frame_rise  = frame_int & ~r_frame_d;
  assign w_new_addr    = ADDR_W'({cpu_wdata[5:0], r_first_byte});

  always_comb begin
    w_status              = 8'h00;
    w_status[STAT_F_BIT]  = r_stat_f;
    w_status[STAT_5S_BIT] = r_stat_5s;
    w_status[STAT_C_BIT]  = r_stat_c;
    w_status[4:0]         = r_stat_num;
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sequencer next state; vram_rd is asserted for exactly the issue cycle
  always_comb begin
    w_state_nxt = r_state;
    w_vram_rd   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start_rd) begin
          w_state_nxt = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        w_vram_rd   = 1'b1;
        w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Counts the VRAM read latency while waiting for read data
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lat_cnt <= '0;
    end else if ((r_state == ST_RD_WAIT) && !w_rd_done) begin
      r_lat_cnt <= r_lat_cnt + CNT_W'(1);
    end else begin
      r_lat_cnt <= '0;
    end
  end

  // VRAM address pointer, write port and read-ahead buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= '0;
      r_vram_addr  <= '0;
      r_vram_wdata <= 8'h00;
      r_vram_wr    <= 1'b0;
      r_read_buf   <= 8'h00;
    end else begin
      r_vram_wr <= 1'b0;
      if (w_data_wr) begin
        r_vram_wr    <= 1'b1;
        r_vram_wdata <= cpu_wdata;
        r_vram_addr  <= r_addr;
        r_read_buf   <= cpu_wdata;
        r_addr       <= r_addr + ADDR_W'(1);
      end else if (w_addr_wr) begin
        r_addr      <= w_new_addr;
        r_vram_addr <= w_new_addr;
      end else if (w_data_rd) begin
        r_vram_addr <= r_addr;
      end
      if (w_rd_done) begin
        r_read_buf <= vram_rdata;
        r_addr     <= r_addr + ADDR_W'(1);
      end
    end
  end

  // Two-byte control sequence: first-byte latch, register writes
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flag       <= 1'b0;
      r_first_byte <= 8'h00;
      r_regs       <= '0;
    end else begin
      if (w_ctl_wr) begin
        if (!r_flag) begin
          r_first_byte <= cpu_wdata;
          r_flag       <= 1'b1;
        end else begin
          r_flag <= 1'b0;
        end
      end else if (w_data_wr || w_data_rd || w_stat_rd) begin
        r_flag <= 1'b0;
      end
      if (w_reg_wr) begin
        r_regs[cpu_wdata[2:0]] <= r_first_byte;
      end
    end
  end

  // CPU read byte, held until the next accepted read
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cpu_rdata <= 8'h00;
    end else if (w_data_rd) begin
      r_cpu_rdata <= r_read_buf;
    end else if (w_stat_rd) begin
      r_cpu_rdata <= w_status;
    end
  end

  // Status latches; a set arriving with a status read survives the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_d  <= 1'b0;
      r_stat_f   <= 1'b0;
      r_stat_5s  <= 1'b0;
      r_stat_c   <= 1'b0;
      r_stat_num <= 5'd0;
    end else begin
      r_frame_d <= frame_int;
      r_stat_f  <= w_frame_rise | (r_stat_f & ~w_stat_rd);
      r_stat_c  <= spr_coll | (r_stat_c & ~w_stat_rd);
      r_stat_5s <= spr_5th | (r_stat_5s & ~w_stat_rd);
      if (spr_5th && !r_stat_5s) begin
        r_stat_num <= spr_5th_num;
      end
    end
  end

  // Sticky flag for strobes that arrive while a read is in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overrun <= 1'b0;
    end else if (w_busy_strobe) begin
      r_overrun <= 1'b1;
    end
  end

  vdp_reg_decode u_decode (
    .regs                      (r_regs),
    .mode                      (mode),
    .name_table_addr           (name_table_addr),
    .font_addr                 (font_addr),
    .color_table_addr          (color_table_addr),
    .sprite_attr_addr          (sprite_attr_addr),
    .sprite_pattern_table_addr (sprite_pattern_table_addr),
    .video_on                  (video_on),
    .sprite_large              (sprite_large),
    .sprite_enlarged           (sprite_enlarged),
    .vert_retrace_int          (vert_retrace_int),
    .text_color                (text_color),
    .back_color                (back_color)
  );

  assign cpu_rdata  = r_cpu_rdata;
  assign vram_addr  = r_vram_addr;
  assign vram_wdata = r_vram_wdata;
  assign vram_wr    = r_vram_wr;
  assign vram_rd    = w_vram_rd;
  assign n_int      = ~(r_stat_f & r_regs[REG_R1][5]);
  assign overrun    = r_overrun;

endmodule : vdp_cpu_port
`default_nettype wire
